// File: rtl/return_addr_stack_if.sv
// Call/return stack bus: the control side drives push/pop requests, the stack
// returns the popped address, its occupancy and its sticky error flags.
interface return_addr_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             clear_err;
  logic [WIDTH-1:0] ret_addr;
  logic             ret_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, push_data, pop, clear_err,
    input  ret_addr, ret_valid, top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop, clear_err,
    output ret_addr, ret_valid, top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// Hardware return-address stack: LIFO of PC+1 values, registered pop output
// that loads the PC, saturating occupancy and sticky overflow/underflow flags.
module return_addr_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  return_addr_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d, cnt_m1;
  logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic             ret_valid_q, ret_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty, full, pop_ok, we;
  logic [AW-1:0]    taddr, waddr;

  // Occupancy only moves by one per edge; a push+pop pair replaces the top in place.
  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                               input logic          do_pop,
                                               input logic          do_push);
    logic [CW-1:0] res;
    res = cnt;
    if (do_pop && !do_push)
      res = cnt - CW'(1);
    else if (do_push && !do_pop)
      res = cnt + CW'(1);
    return res;
  endfunction

  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == CW'(DEPTH));
    cnt_m1 = count_q - CW'(1);
    taddr  = cnt_m1[AW-1:0];
    pop_ok = bus.pop && !empty;
    // A push alongside a pop is never blocked by full: it either replaces the top or fills slot 0.
    we     = bus.push && (bus.pop || !full);
    waddr  = pop_ok ? taddr : count_q[AW-1:0];

    count_d     = next_count(count_q, pop_ok, we);
    ret_valid_d = pop_ok;
    ret_addr_d  = pop_ok ? mem_q[taddr] : ret_addr_q;
    ovf_d       = (bus.push && !bus.pop && full) || (ovf_q && !bus.clear_err);
    unf_d       = (bus.pop && empty) || (unf_q && !bus.clear_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Storage is data only: never reset, and writes are ignored while reset is held.
  always_ff @(posedge clk) begin
    if (reset && we)
      mem_q[waddr] <= bus.push_data;
  end

  assign bus.ret_addr  = ret_addr_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.top       = empty ? '0 : mem_q[taddr];
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: queue-based reference model checked every cycle,
// directed literal checks of the model, then biased random push/pop/clear/reset.
module tb_return_addr_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  return_addr_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  return_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    else
      n_pass++;
  endtask

  // Reference model: a plain queue whose back is the top of stack.
  logic [WIDTH-1:0] stk [$];
  logic [WIDTH-1:0] m_ra  = '0;
  logic             m_rv  = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk.delete();
      m_ra  = '0;
      m_rv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      bit so, su;
      so   = 1'b0;
      su   = 1'b0;
      m_rv = 1'b0;
      if (bus.pop) begin
        if (stk.size() == 0) begin
          su = 1'b1;
          if (bus.push) stk.push_back(bus.push_data);
        end else begin
          m_ra = stk[stk.size()-1];
          m_rv = 1'b1;
          if (bus.push) stk[stk.size()-1] = bus.push_data;
          else void'(stk.pop_back());
        end
      end else if (bus.push) begin
        if (stk.size() < DEPTH) stk.push_back(bus.push_data);
        else so = 1'b1;
      end
      m_ovf = so | (m_ovf & ~bus.clear_err);
      m_unf = su | (m_unf & ~bus.clear_err);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",     32'(bus.count),     32'(stk.size()));
      chk("empty",     32'(bus.empty),     32'(stk.size() == 0));
      chk("full",      32'(bus.full),      32'(stk.size() == DEPTH));
      chk("top",       32'(bus.top),       (stk.size() == 0) ? 32'd0 : 32'(stk[stk.size()-1]));
      chk("ret_valid", 32'(bus.ret_valid), 32'(m_rv));
      chk("ret_addr",  32'(bus.ret_addr),  32'(m_ra));
      chk("overflow",  32'(bus.overflow),  32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input logic p, input logic [WIDTH-1:0] pd, input logic po, input logic clr);
    bus.push      = p;
    bus.push_data = pd;
    bus.pop       = po;
    bus.clear_err = clr;
    @(posedge clk);
    #1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.clear_err = 1'b0;
  endtask

  initial begin
    bus.push      = 1'b0;
    bus.push_data = '0;
    bus.pop       = 1'b0;
    bus.clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst count",     32'(bus.count),     32'd0);
    chk("rst ret_valid", 32'(bus.ret_valid), 32'd0);
    chk("rst ret_addr",  32'(bus.ret_addr),  32'd0);
    chk("rst flags",     32'({bus.overflow, bus.underflow}), 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;

    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("idle empty", 32'(bus.empty), 32'd1);
    chk("idle full",  32'(bus.full),  32'd0);
    chk("idle top",   32'(bus.top),   32'd0);

    cyc(1'b1, 16'h1112, 1'b0, 1'b0);
    cyc(1'b1, 16'h2000, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("pop1 valid", 32'(bus.ret_valid), 32'd1);
    chk("pop1 addr",  32'(bus.ret_addr),  32'h2000);
    chk("pop1 count", 32'(bus.count),     32'd1);
    chk("pop1 top",   32'(bus.top),       32'h1112);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("pop2 addr",  32'(bus.ret_addr), 32'h1112);
    chk("pop2 empty", 32'(bus.empty),    32'd1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("hold valid", 32'(bus.ret_valid), 32'd0);
    chk("hold addr",  32'(bus.ret_addr),  32'h1112);

    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    chk("fill full",  32'(bus.full),  32'd1);
    chk("fill count", 32'(bus.count), 32'd8);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("ovf flag",  32'(bus.overflow), 32'd1);
    chk("ovf count", 32'(bus.count),    32'd8);
    chk("ovf top",   32'(bus.top),      32'h0107);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      chk("drain valid", 32'(bus.ret_valid), 32'd1);
      chk("drain addr",  32'(bus.ret_addr),  32'(16'(16'h0107 - i)));
    end

    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("unf valid", 32'(bus.ret_valid), 32'd0);
    chk("unf flag",  32'(bus.underflow), 32'd1);
    chk("unf addr",  32'(bus.ret_addr),  32'h0100);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("clr flags", 32'({bus.overflow, bus.underflow}), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    chk("set wins", 32'(bus.underflow), 32'd1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);

    cyc(1'b1, 16'hAAAA, 1'b0, 1'b0);
    cyc(1'b1, 16'hBBBB, 1'b0, 1'b0);
    cyc(1'b1, 16'hCCCC, 1'b1, 1'b0);
    chk("swap addr",  32'(bus.ret_addr),  32'hBBBB);
    chk("swap valid", 32'(bus.ret_valid), 32'd1);
    chk("swap count", 32'(bus.count),     32'd2);
    chk("swap top",   32'(bus.top),       32'hCCCC);
    for (int i = 0; i < DEPTH - 2; i++) cyc(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 1'b1, 1'b0);
    chk("fswap ovf",   32'(bus.overflow), 32'd0);
    chk("fswap count", 32'(bus.count),    32'd8);
    chk("fswap top",   32'(bus.top),      32'h5555);
    chk("fswap addr",  32'(bus.ret_addr), 32'h3005);

    reset = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("pre-rst valid", 32'(bus.ret_valid), 32'd1);
    chk("pre-rst addr",  32'(bus.ret_addr),  32'h1234);
    #2 reset = 1'b0;
    #1;
    chk("async valid", 32'(bus.ret_valid), 32'd0);
    chk("async count", 32'(bus.count),     32'd0);
    chk("async empty", 32'(bus.empty),     32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post-rst unf",   32'(bus.underflow), 32'd1);
    chk("post-rst valid", 32'(bus.ret_valid), 32'd0);

    for (int n = 0; n < 2000; n++) begin
      int pp, pq;
      pp = (n < 1000) ? 60 : 35;
      pq = (n < 1000) ? 35 : 60;
      cyc(logic'($urandom_range(0, 99) < pp), 16'($urandom),
          logic'($urandom_range(0, 99) < pq), logic'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware call/return stack that pairs with the program counter.
- On a call, the fetch path pushes the return address (PC+1). On a return, the block pops that address and presents it, registered, as a load value back into the PC.
- Sits between the control decoder and the PC. ret_addr drives the PC in port and ret_valid drives the PC load port.
- LIFO storage with occupancy tracking, sticky overflow/underflow flags and defined simultaneous push/pop behaviour.

Parameters:
- WIDTH, 16, address width (matches PC width).
- DEPTH, 8, number of stack entries; must be >= 2.
- CW, $clog2(DEPTH+1), width of count (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low (reset=0 clears state).
- push  in  1  push push_data this cycle.
- push_data  in  WIDTH  return address to store.
- pop  in  1  pop top entry this cycle.
- clear_err  in  1  synchronous clear of overflow/underflow.
- ret_addr  out  WIDTH  popped address, registered.
- ret_valid  out  1  one-cycle pulse: ret_addr valid, drives PC load.
- top  out  WIDTH  current top entry (combinational from storage); 0 when empty.
- count  out  CW  occupancy, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous assert):
  - count=0, ret_addr=0, ret_valid=0, overflow=0, underflow=0.
  - Storage contents need not be cleared; top reads 0 because empty=1.
- Deassertion of reset is synchronised externally. First active edge is the first rising clk with reset=1.
- Storage: DEPTH x WIDTH register array with stack pointer sp=count. The top entry is mem[count-1].
- Per rising edge, priority decision on {push,pop}:
  - 00: hold. ret_valid=0.
  - 10, not full: mem[count]<=push_data; count+1. ret_valid=0.
  - 10, full: push dropped; contents and count unchanged; overflow<=1.
  - 01, not empty: ret_addr<=mem[count-1]; ret_valid<=1; count-1.
  - 01, empty: ret_valid=0; ret_addr holds; underflow<=1.
  - 11, not empty: ret_addr<=mem[count-1]; ret_valid<=1; mem[count-1]<=push_data; count unchanged. Applies even when full, with no overflow.
  - 11, empty: underflow<=1; push performed (mem[0]<=push_data, count=1); ret_valid=0.
- Latency:
  - pop -> ret_valid/ret_addr visible one cycle after the sampling edge, i.e. on the same edge that updates count.
  - ret_valid is high for exactly one cycle per successful pop. Back-to-back pops give back-to-back pulses with successive addresses.
- ret_addr holds its last popped value when ret_valid=0.
- top, empty, full are derived from count and storage. They update on the same edge as count.
- Sticky flags:
  - Set per the rules above and remain set until clear_err=1 at a clock edge or reset.
  - If clear_err coincides with a new error event, the set wins (flag=1).
- No wrap-around: pointer never exceeds DEPTH or goes below 0. All count arithmetic is saturating by construction.
- Reset asserted mid-operation clears state immediately. Any in-flight ret_valid pulse is cancelled (drops to 0 asynchronously).
- X on push/pop while reset=0 has no effect.

Test Plan:
- Reset then idle -> count=0, empty=1, full=0, top=0, ret_valid=0, flags=0.
- Push 16'h1112, push 16'h2000, pop -> next cycle ret_valid=1, ret_addr=16'h2000, count=1, top=16'h1112. Second pop -> ret_addr=16'h1112, empty=1.
- Push 8 values 16'h0100..16'h0107 -> full=1, count=8. 9th push 16'hDEAD -> overflow=1, count=8, top=16'h0107. Then 8 pops return 16'h0107..16'h0100 in consecutive ret_valid pulses.
- Pop on empty -> ret_valid=0, underflow=1, ret_addr unchanged. clear_err=1 one cycle -> underflow=0.
- Stack {16'hAAAA,16'hBBBB}, push+pop with push_data 16'hCCCC -> ret_addr=16'hBBBB, ret_valid=1, count=2, top=16'hCCCC. Same while full -> no overflow.
- Push 16'h1234, pop, assert reset=0 between edges while ret_valid=1 -> ret_valid=0 and count=0 immediately; after release, first pop sets underflow.
